// File: rtl/fpu_op_issue.sv
// Operand issue buffer in front of the FPU core: a first-word-fall-through FIFO that classifies
// operands at enqueue. Optional special-case result resolution is enabled by FPU_SPECIAL_BYPASS_EN.
module fpu_op_issue #(
  parameter int DEPTH = 4,
  parameter int C_OP  = 32,
  parameter int C_CMD = 4,
  parameter int C_RM  = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [C_OP-1:0]          operand_a_i,
  input  logic [C_OP-1:0]          operand_b_i,
  input  logic [C_CMD-1:0]         op_i,
  input  logic [C_RM-1:0]          rm_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [C_OP-1:0]          operand_a_o,
  output logic [C_OP-1:0]          operand_b_o,
  output logic [C_CMD-1:0]         op_o,
  output logic [C_RM-1:0]          rm_o,
  output logic [4:0]               class_a_o,
  output logic [4:0]               class_b_o,
  output logic                     illegal_o,
  output logic                     special_o,
  output logic [C_OP-1:0]          special_res_o,
  output logic                     special_nv_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]    FULL   = CW'(DEPTH);
  localparam logic [C_CMD-1:0] OP_ADD = C_CMD'(4'b0010);
  localparam logic [C_CMD-1:0] OP_SUB = C_CMD'(4'b0011);
  localparam logic [C_CMD-1:0] OP_MUL = C_CMD'(4'b0001);
  localparam logic [C_RM-1:0]  RM_MAX = C_RM'(3'h4);

  typedef struct packed {
    logic [C_OP-1:0]  a;
    logic [C_OP-1:0]  b;
    logic [C_CMD-1:0] op;
    logic [C_RM-1:0]  rm;
    logic [4:0]       ca;
    logic [4:0]       cb;
    logic             illegal;
  } entry_t;

  // Class bits are {snan, nan, inf, zero, denorm}; snan implies nan.
  function automatic logic [4:0] classify(input logic [7:0] e, input logic [22:0] m);
    logic nan;
    nan = (e == 8'hff) && (m != '0);
    return {nan && !m[22], nan, (e == 8'hff) && (m == '0), (e == '0) && (m == '0),
            (e == '0) && (m != '0)};
  endfunction

  // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
  // valid never depends on ready, and in_ready_o comes only from the registered count.
  logic          push, pop;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  entry_t        mem [DEPTH];
  entry_t        in_entry;
  logic [4:0]    cls_a, cls_b;
  logic          in_illegal;

  assign in_ready_o  = (count != FULL);
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign count_o     = count;

  assign cls_a      = classify(operand_a_i[30:23], operand_a_i[22:0]);
  assign cls_b      = classify(operand_b_i[30:23], operand_b_i[22:0]);
  assign in_illegal = !((op_i == OP_ADD) || (op_i == OP_SUB) || (op_i == OP_MUL)) ||
                      (rm_i > RM_MAX);

  always_comb begin
    in_entry         = '0;
    in_entry.a       = operand_a_i;
    in_entry.b       = operand_b_i;
    in_entry.op      = op_i;
    in_entry.rm      = rm_i;
    in_entry.ca      = cls_a;
    in_entry.cb      = cls_b;
    in_entry.illegal = in_illegal;
  end

`ifdef FPU_SPECIAL_BYPASS_EN
  localparam logic [C_OP-1:0] QNAN = C_OP'(32'h7FC00000);

  typedef struct packed {
    logic            hit;
    logic [C_OP-1:0] res;
    logic            nv;
  } spec_t;

  spec_t sp_mem [DEPTH];
  spec_t sp_in;
  logic  sign_a, sign_b_eff;

  // Special results are resolved here so the core can skip them; illegal requests never resolve.
  always_comb begin
    sp_in      = '0;
    sign_a     = operand_a_i[31];
    sign_b_eff = operand_b_i[31] ^ (op_i == OP_SUB);
    if (!in_illegal) begin
      if (cls_a[3] || cls_b[3]) begin
        sp_in = '{hit: 1'b1, res: QNAN, nv: cls_a[4] | cls_b[4]};
      end else if (op_i == OP_MUL) begin
        if ((cls_a[2] && cls_b[1]) || (cls_a[1] && cls_b[2])) begin
          sp_in = '{hit: 1'b1, res: QNAN, nv: 1'b1};
        end else if (cls_a[2] || cls_b[2]) begin
          sp_in = '{hit: 1'b1, res: C_OP'({sign_a ^ operand_b_i[31], 8'hff, 23'h0}), nv: 1'b0};
        end
      end else begin
        if (cls_a[2] && cls_b[2] && (sign_a != sign_b_eff)) begin
          sp_in = '{hit: 1'b1, res: QNAN, nv: 1'b1};
        end else if (cls_a[2]) begin
          sp_in = '{hit: 1'b1, res: C_OP'({sign_a, 8'hff, 23'h0}), nv: 1'b0};
        end else if (cls_b[2]) begin
          sp_in = '{hit: 1'b1, res: C_OP'({sign_b_eff, 8'hff, 23'h0}), nv: 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sp_mem[i] <= '0;
    end else if (!flush_i && push) begin
      sp_mem[wr_ptr] <= sp_in;
    end
  end

  assign special_o     = sp_mem[rd_ptr].hit;
  assign special_res_o = sp_mem[rd_ptr].res;
  assign special_nv_o  = sp_mem[rd_ptr].nv;
`else
  assign special_o     = 1'b0;
  assign special_res_o = '0;
  assign special_nv_o  = 1'b0;
`endif

  // Storage is cleared on reset so the head fields read 0 until the first push.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_entry;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  assign operand_a_o = mem[rd_ptr].a;
  assign operand_b_o = mem[rd_ptr].b;
  assign op_o        = mem[rd_ptr].op;
  assign rm_o        = mem[rd_ptr].rm;
  assign class_a_o   = mem[rd_ptr].ca;
  assign class_b_o   = mem[rd_ptr].cb;
  assign illegal_o   = mem[rd_ptr].illegal;

endmodule
